// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : pe_feeder
//  Description : Sequences one PE run: replays a stored instruction program,
//                streams a full register-file burst from a data FIFO, times
//                the iteration loop, flags the last iteration (alpha) and
//                captures the PE result.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int REG_NUM    = 8,
    parameter int INST_NUM   = 16,
    parameter int ITER_NUM   = 4,
    parameter int ITER_LEN   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_clr,
    input  logic                    cfg_inst_v,
    input  logic [INST_WIDTH-1:0]   cfg_inst,
    input  logic                    s_v,
    input  logic [DATA_WIDTH*2-1:0] s_data,
    output logic                    s_rdy,
    input  logic                    start,
    output logic                    inst_in_v,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    din_pe_v,
    output logic [DATA_WIDTH*2-1:0] din_pe,
    output logic                    alpha_v,
    input  logic                    dout_pe_v,
    input  logic [DATA_WIDTH*2-1:0] dout_pe,
    output logic                    m_v,
    output logic [DATA_WIDTH*2-1:0] m_data,
    output logic                    busy,
    output logic                    done
);

    localparam int C_WORD_W  = DATA_WIDTH * 2;
    localparam int C_DEPTH   = REG_NUM * 2;
    localparam int C_PTR_W   = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int C_FCNT_W  = $clog2(C_DEPTH + 1);
    localparam int C_IDX_W   = (INST_NUM > 1) ? $clog2(INST_NUM) : 1;
    localparam int C_ICNT_W  = $clog2(INST_NUM + 1);
    localparam int C_SEQ_MAX = (INST_NUM > C_DEPTH) ? INST_NUM : C_DEPTH;
    localparam int C_SEQ_W   = $clog2(C_SEQ_MAX + 1);
    localparam int C_ITER_W  = (ITER_NUM > 1) ? $clog2(ITER_NUM) : 1;
    localparam int C_LEN_W   = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_INST = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_SEND_DATA = 3'd3,
        S_RUN       = 3'd4,
        S_DRAIN     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [C_ICNT_W-1:0]   inst_cnt_q, inst_cnt_d;
    logic [C_SEQ_W-1:0]    seq_q, seq_d;       // word index in SEND_INST/SEND_DATA, cycle in DRAIN
    logic [C_ITER_W-1:0]   iter_q, iter_d;
    logic [C_LEN_W-1:0]    cyc_q, cyc_d;
    logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                  alpha_d1_q, alpha_d1_d;
    logic                  m_v_q, m_v_d;
    logic [C_WORD_W-1:0]   m_data_q, m_data_d;

    logic [INST_WIDTH-1:0] inst_mem_q [INST_NUM];
    logic [C_WORD_W-1:0]   fifo_mem_q [C_DEPTH];

    logic inst_we;
    logic push;
    logic pop;
    logic full;
    logic last_inst;

    assign full      = (fcnt_q == C_FCNT_W'(C_DEPTH));
    assign s_rdy     = !full;
    assign push      = s_v && !full;
    assign last_inst = (seq_q == (C_SEQ_W'(inst_cnt_q) - C_SEQ_W'(1)));
    assign m_v       = m_v_q;
    assign m_data    = m_data_q;

    // FIFO pointer and occupancy bookkeeping; pop is owned by the FSM
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == C_PTR_W'(C_DEPTH - 1)) ? '0 : wr_ptr_q + C_PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == C_PTR_W'(C_DEPTH - 1)) ? '0 : rd_ptr_q + C_PTR_W'(1);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + C_FCNT_W'(1);
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - C_FCNT_W'(1);
        end
    end

    // Main sequencer: next state, counters and PE-side strobes
    always_comb begin
        state_d    = state_q;
        inst_cnt_d = inst_cnt_q;
        seq_d      = seq_q;
        iter_d     = iter_q;
        cyc_d      = cyc_q;
        inst_we    = 1'b0;
        pop        = 1'b0;
        inst_in_v  = 1'b0;
        inst_in    = '0;
        din_pe_v   = 1'b0;
        din_pe     = '0;
        alpha_v    = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (cfg_clr) begin
                    inst_cnt_d = '0;
                end else if (cfg_inst_v && (inst_cnt_q < C_ICNT_W'(INST_NUM))) begin
                    inst_we    = 1'b1;
                    inst_cnt_d = inst_cnt_q + C_ICNT_W'(1);
                end
                if (start && (inst_cnt_q != '0)) begin
                    state_d = S_SEND_INST;
                    seq_d   = '0;
                end
            end
            S_SEND_INST: begin
                inst_in_v = 1'b1;
                inst_in   = inst_mem_q[seq_q[C_IDX_W-1:0]];
                if (last_inst) begin
                    seq_d = '0;
                    // A burst already waiting skips WAIT_DATA so data follows without a bubble
                    state_d = full ? S_SEND_DATA : S_WAIT_DATA;
                end else begin
                    seq_d = seq_q + C_SEQ_W'(1);
                end
            end
            S_WAIT_DATA: begin
                if (full) begin
                    state_d = S_SEND_DATA;
                    seq_d   = '0;
                end
            end
            S_SEND_DATA: begin
                pop      = 1'b1;
                din_pe_v = 1'b1;
                din_pe   = fifo_mem_q[rd_ptr_q];
                if (seq_q == C_SEQ_W'(C_DEPTH - 1)) begin
                    state_d = S_RUN;
                    seq_d   = '0;
                    iter_d  = '0;
                    cyc_d   = '0;
                end else begin
                    seq_d = seq_q + C_SEQ_W'(1);
                end
            end
            S_RUN: begin
                alpha_v = (iter_q == C_ITER_W'(ITER_NUM - 1));
                if (cyc_q == C_LEN_W'(ITER_LEN - 1)) begin
                    cyc_d = '0;
                    if (iter_q == C_ITER_W'(ITER_NUM - 1)) begin
                        iter_d  = '0;
                        state_d = S_DRAIN;
                        seq_d   = '0;
                    end else begin
                        iter_d = iter_q + C_ITER_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + C_LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if (seq_q == C_SEQ_W'(1)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + C_SEQ_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result capture one cycle behind alpha; m_data holds between captures
    always_comb begin
        alpha_d1_d = alpha_v;
        m_v_d      = alpha_d1_q & dout_pe_v;
        m_data_d   = m_v_d ? dout_pe : m_data_q;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            inst_cnt_q <= '0;
            seq_q      <= '0;
            iter_q     <= '0;
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            alpha_d1_q <= 1'b0;
            m_v_q      <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            inst_cnt_q <= inst_cnt_d;
            seq_q      <= seq_d;
            iter_q     <= iter_d;
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            alpha_d1_q <= alpha_d1_d;
            m_v_q      <= m_v_d;
            m_data_q   <= m_data_d;
        end
    end

    // Storage arrays need no reset: contents are only read behind valid counts
    always_ff @(posedge clk) begin
        if (inst_we) begin
            inst_mem_q[inst_cnt_q[C_IDX_W-1:0]] <= cfg_inst;
        end
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_feeder
//  Description : Directed self-checking bench for pe_feeder
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_feeder;

    logic        clk;
    logic        rst;
    logic        cfg_clr;
    logic        cfg_inst_v;
    logic [31:0] cfg_inst;
    logic        s_v;
    logic [31:0] s_data;
    logic        s_rdy;
    logic        start;
    logic        inst_in_v;
    logic [31:0] inst_in;
    logic        din_pe_v;
    logic [31:0] din_pe;
    logic        alpha_v;
    logic        dout_pe_v;
    logic [31:0] dout_pe;
    logic        m_v;
    logic [31:0] m_data;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    pe_feeder #(
        .DATA_WIDTH(16), .INST_WIDTH(32), .REG_NUM(8),
        .INST_NUM(16), .ITER_NUM(4), .ITER_LEN(20)
    ) dut (
        .clk(clk), .rst(rst), .cfg_clr(cfg_clr), .cfg_inst_v(cfg_inst_v),
        .cfg_inst(cfg_inst), .s_v(s_v), .s_data(s_data), .s_rdy(s_rdy),
        .start(start), .inst_in_v(inst_in_v), .inst_in(inst_in),
        .din_pe_v(din_pe_v), .din_pe(din_pe), .alpha_v(alpha_v),
        .dout_pe_v(dout_pe_v), .dout_pe(dout_pe), .m_v(m_v), .m_data(m_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_insts(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            cfg_inst_v = 1'b1;
            cfg_inst   = base + 32'(i);
            step();
        end
        cfg_inst_v = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            s_v    = 1'b1;
            s_data = base + 32'(i);
            step();
        end
        s_v = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk(tag, 96'(busy), 96'd0);
    endtask

    // Full run with a 16-word burst already queued; k counts cycles after the start cycle
    task automatic run_check(input logic [31:0] ibase, input int ni, input logic [31:0] dbase,
                             input logic cap);
        logic        e_iv, e_dv, e_al, e_done, e_busy, e_mv;
        logic [31:0] e_ii, e_d, e_md;
        int          rs;
        rs = ni + 17;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= rs + 82; k++) begin
            e_iv   = (k <= ni);
            e_ii   = e_iv ? ibase + 32'(k - 1) : 32'd0;
            e_dv   = (k > ni) && (k <= ni + 16);
            e_d    = e_dv ? dbase + 32'(k - ni - 1) : 32'd0;
            e_al   = (k >= rs + 60) && (k < rs + 80);
            e_done = (k == rs + 81);
            e_busy = (k <= rs + 81);
            e_mv   = cap && (k >= rs + 62) && (k <= rs + 81);
            e_md   = (cap && (k >= rs + 62)) ? 32'h0001_0002 : 32'd0;
            chk("run_outputs", 96'({inst_in_v, din_pe_v, alpha_v, done, busy, inst_in, din_pe}),
                96'({e_iv, e_dv, e_al, e_done, e_busy, e_ii, e_d}));
            chk("capture", 96'({m_v, m_data}), 96'({e_mv, e_md}));
            start = (k == rs + 30);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_clr = 1'b0; cfg_inst_v = 1'b0; cfg_inst = '0;
        s_v = 1'b0; s_data = '0; start = 1'b0; dout_pe_v = 1'b0; dout_pe = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", 96'({busy, s_rdy, m_v, m_data, inst_in_v, din_pe_v, alpha_v, done}),
            96'({1'b0, 1'b1, 1'b0, 32'd0, 4'b0000}));

        // Basic run: 3 instructions, full burst, start ignored mid-RUN
        load_insts(3, 32'hA000_0000);
        push_words(16, 32'h0000_1000);
        chk("full_rdy", 96'(s_rdy), 96'd0);
        run_check(32'hA000_0000, 3, 32'h0000_1000, 1'b0);

        // Replay without reconfiguration, with result capture
        push_words(16, 32'h0000_2000);
        dout_pe_v = 1'b1;
        dout_pe   = 32'h0001_0002;
        run_check(32'hA000_0000, 3, 32'h0000_2000, 1'b1);
        dout_pe_v = 1'b0;
        dout_pe   = 32'hFFFF_FFFF;
        step();
        chk("m_data_hold", 96'({m_v, m_data}), 96'({1'b0, 32'h0001_0002}));

        // Data shortfall: hold in WAIT_DATA until the burst is complete
        push_words(10, 32'h0000_3000);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("short_hold", 96'({busy, inst_in_v, din_pe_v}), 96'(3'b100));
        push_words(6, 32'h0000_300A);
        chk("short_pre", 96'(din_pe_v), 96'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("short_burst", 96'({din_pe_v, din_pe}), 96'({1'b1, 32'h0000_3000 + 32'(i)}));
            step();
        end
        chk("short_end", 96'({din_pe_v, busy}), 96'(2'b01));
        wait_idle("short_idle");

        // Overflow and instruction saturation
        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
        load_insts(20, 32'hB000_0000);
        s_v = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_data = 32'h0000_4000 + 32'(i);
            if (i == 15) chk("ovf_rdy15", 96'(s_rdy), 96'd1);
            if (i == 16) chk("ovf_rdy16", 96'(s_rdy), 96'd0);
            step();
        end
        s_v = 1'b0;
        chk("ovf_rdy_after", 96'(s_rdy), 96'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            chk("sat_seq", 96'({inst_in_v, inst_in, din_pe_v, din_pe}),
                96'({(k <= 16), (k <= 16) ? 32'hB000_0000 + 32'(k - 1) : 32'd0,
                     (k >= 17 && k <= 32), (k >= 17 && k <= 32) ? 32'h0000_4000 + 32'(k - 17) : 32'd0}));
            step();
        end
        wait_idle("sat_idle");
        chk("sat_fifo_empty", 96'(s_rdy), 96'd1);

        // Clear wins over write; start with an empty program is ignored
        cfg_clr    = 1'b1;
        cfg_inst_v = 1'b1;
        cfg_inst   = 32'hDEAD_BEEF;
        step();
        cfg_clr    = 1'b0;
        cfg_inst_v = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clr_start", 96'({busy, inst_in_v}), 96'(2'b00));
        step();
        chk("clr_start2", 96'(busy), 96'd0);

        // Reset in the 5th SEND_DATA cycle
        load_insts(2, 32'hC000_0000);
        push_words(16, 32'h0000_5000);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("rst_burst", 96'({din_pe_v, din_pe}), 96'({1'b1, 32'h0000_5000 + 32'(i)}));
            if (i == 4) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        chk("rst_abort", 96'({din_pe_v, busy, s_rdy, inst_in_v, alpha_v}), 96'(5'b00100));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_start_ign", 96'(busy), 96'd0);
        load_insts(1, 32'hE000_0000);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("reload_start", 96'({busy, inst_in_v, inst_in}), 96'({2'b11, 32'hE000_0000}));
        push_words(16, 32'h0000_6000);
        wait_idle("reload_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameters SHALL be as follows (one per line: name, default, meaning).
- DATA_WIDTH, 16, real/imag component width; a complex word is DATA_WIDTH*2 bits.
- INST_WIDTH, 32, PE instruction width.
- REG_NUM, 8, PE register count; one data burst is REG_NUM*2 words.
- INST_NUM, 16, instruction buffer depth.
- ITER_NUM, 4, iterations per run; must be at least 1.
- ITER_LEN, 20, cycles per iteration; must be at least 1.

REQ-002 Ports SHALL be as follows (one per line: name, direction, width, meaning).
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- cfg_clr, in, 1, clears the instruction buffer.
- cfg_inst_v, in, 1, instruction write strobe.
- cfg_inst, in, INST_WIDTH, instruction word to write.
- s_v, in, 1, host data valid.
- s_data, in, DATA_WIDTH*2, host complex data word.
- s_rdy, out, 1, data FIFO can accept a word.
- start, in, 1, run request pulse.
- inst_in_v, out, 1, instruction valid to the PE.
- inst_in, out, INST_WIDTH, instruction word to the PE.
- din_pe_v, out, 1, data valid to the PE.
- din_pe, out, DATA_WIDTH*2, data word to the PE.
- alpha_v, out, 1, last-iteration flag to the PE.
- dout_pe_v, in, 1, PE result valid; sticky, never cleared by the PE.
- dout_pe, in, DATA_WIDTH*2, PE result word.
- m_v, out, 1, captured result valid.
- m_data, out, DATA_WIDTH*2, captured result word.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle run-complete pulse.

Function
REQ-003 FSM states SHALL be IDLE, SEND_INST, WAIT_DATA, SEND_DATA, RUN, DRAIN.

REQ-004 In IDLE, each cfg_inst_v cycle SHALL write cfg_inst at index inst_cnt and increment inst_cnt.
- inst_cnt saturates at INST_NUM; writes beyond that are dropped.
- cfg_clr sets inst_cnt to 0.
- cfg_clr takes priority over cfg_inst_v in the same cycle.
- Both inputs are ignored outside IDLE.

REQ-005 The data FIFO SHALL be REG_NUM*2 words deep and SHALL behave as follows.
- s_rdy = !full.
- A word is pushed when s_v && s_rdy.
- Push and pop in the same cycle leave the count unchanged.
- Pushes are accepted in every state.

REQ-006 IDLE->SEND_INST SHALL occur only when start=1 and inst_cnt>0.
- start with inst_cnt=0 is ignored.
- start in any other state is ignored.

REQ-007 SEND_INST SHALL behave as follows.
- Drives inst_in_v=1 with buffer words 0..inst_cnt-1, one per cycle and contiguous.
- The first word appears in the cycle after the start cycle.
- Then goes to WAIT_DATA.

REQ-008 WAIT_DATA SHALL go to SEND_DATA when the FIFO count equals REG_NUM*2.

REQ-009 SEND_DATA SHALL pop exactly REG_NUM*2 words on consecutive cycles.
- Each popped word drives din_pe_v=1 with that word on din_pe.
- There are no gaps; the PE load counter requires an unbroken burst.
- Then goes to RUN.

REQ-010 RUN SHALL last ITER_NUM*ITER_LEN cycles, counted by an iteration counter and a cycle counter.
- alpha_v=1 for exactly the final ITER_LEN cycles; 0 otherwise.

REQ-011 Result capture SHALL register as m_v <= alpha_v_d1 & dout_pe_v and m_data <= dout_pe.
- alpha_v_d1 is alpha_v delayed by one cycle.
- m_data holds its value when m_v=0.

REQ-012 DRAIN SHALL last 2 cycles.
- done=1 in the last DRAIN cycle.
- The next state is IDLE.

REQ-013 When not driven active, outputs SHALL be 0.
- This applies to inst_in_v, din_pe_v, alpha_v, inst_in and din_pe.
- busy=1 in every state except IDLE.

REQ-014 The instruction buffer SHALL retain its contents across runs.
- A second start after done replays the same program without reconfiguration.

Reset
REQ-015 rst=1 SHALL, on the next edge, set the following regardless of state:
- state=IDLE;
- FIFO empty, so s_rdy=1;
- inst_cnt=0;
- all counters 0;
- all outputs 0, including m_data.

REQ-016 Reset mid-SEND_DATA or mid-RUN SHALL abort the run with no further PE-side strobes.

Verification
REQ-017 The bench SHALL cover the following directed scenarios (REG_NUM=8, INST_NUM=16, ITER_NUM=4, ITER_LEN=20).
- Basic run: load 3 instructions, push 16 words, start at cycle t.
  - Expect inst_in_v during t+1..t+3 and din_pe_v during t+4..t+19 in FIFO order.
  - Expect RUN for 80 cycles with alpha_v high in its last 20.
  - Expect done 2 cycles after RUN ends.
- Data shortfall: push 10 words, then start.
  - The FSM holds in WAIT_DATA.
  - Pushing 6 more words starts a 16-cycle gapless din_pe_v burst.
- Overflow and saturation:
  - Push 17 words with s_v held high: word 17 is refused, s_rdy=0.
  - 20 cfg_inst_v writes: inst_cnt=16 and SEND_INST lasts 16 cycles.
- Ignored starts and clear priority:
  - start with inst_cnt=0 leaves busy=0.
  - start during RUN has no effect.
  - cfg_clr together with cfg_inst_v leaves inst_cnt=0.
- Capture: dout_pe_v=1 with dout_pe=0x00010002 while alpha_v is active.
  - Expect m_v=1 with m_data=0x00010002 two cycles after alpha_v rises.
  - Expect m_v=0 before that.
- Reset: rst asserted in the 5th cycle of SEND_DATA.
  - The next cycle has din_pe_v=0, busy=0 and s_rdy=1.
  - A subsequent start is ignored until instructions are reloaded.
